// File: rtl/regfile_pkg.sv
// Shared opcode, register-function and FSM-state encodings for the
// register-file controller and its testbench.
package regfile_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LDI    = 3'b001;
  localparam logic [2:0] OP_MOV    = 3'b010;
  localparam logic [2:0] OP_SWP    = 3'b011;
  localparam logic [2:0] OP_INC    = 3'b100;
  localparam logic [2:0] OP_DEC    = 3'b101;
  localparam logic [2:0] OP_CLR    = 3'b110;
  localparam logic [2:0] OP_CLRALL = 3'b111;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WR1  = 2'd2;
  localparam logic [1:0] ST_WR2  = 2'd3;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
  } cmd_t;

  // MOV and SWP need the operands fetched before anything is written.
  function automatic logic needs_read(input logic [2:0] op);
    return (op == OP_MOV) || (op == OP_SWP);
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// One-hot decode of a 3-bit register address: 0..3 -> R1..R4, 4..7 -> S1..S4,
// with R1/S1 on bit 3 of their respective enable vectors.
module addr_decoder (
  input  logic [2:0] addr,
  output logic [3:0] reg_sel,
  output logic [3:0] scr_sel
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign reg_sel[3-gi] = (addr == 3'(gi));
    assign scr_sel[3-gi] = (addr == 3'(gi + 4));
  end

endmodule

// File: rtl/regfile_controller.sv
// Command sequencer for an 8-entry register file (R1..R4, S1..S4): accepts one
// command at a time and drives read selects, write enables and function codes.
module regfile_controller
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [2:0]        CmdOp,
  input  logic [2:0]        CmdDst,
  input  logic [2:0]        CmdSrc,
  input  logic [DATA_W-1:0] CmdImm,
  output logic              Done,
  output logic [DATA_W-1:0] RfI,
  output logic [3:0]        RegSel,
  output logic [3:0]        ScrSel,
  output logic [2:0]        FunSel,
  output logic [2:0]        OutASel,
  output logic [2:0]        OutBSel,
  input  logic [DATA_W-1:0] RfOutA,
  input  logic [DATA_W-1:0] RfOutB
);

  logic [1:0]        state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] ta_q, ta_d;
  logic [DATA_W-1:0] tb_q, tb_d;
  logic              done_q, done_d;

  logic [3:0] dst_reg_sel, dst_scr_sel;
  logic [3:0] src_reg_sel, src_scr_sel;

  addr_decoder u_dst_dec (
    .addr    (cmd_q.dst),
    .reg_sel (dst_reg_sel),
    .scr_sel (dst_scr_sel)
  );

  addr_decoder u_src_dec (
    .addr    (cmd_q.src),
    .reg_sel (src_reg_sel),
    .scr_sel (src_scr_sel)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    imm_d   = imm_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          cmd_d = '{op: CmdOp, dst: CmdDst, src: CmdSrc};
          imm_d = CmdImm;
          if (CmdOp == OP_NOP) begin
            done_d = 1'b1;
          end else if (needs_read(CmdOp)) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WR1;
          end
        end
      end
      ST_READ: begin
        ta_d    = RfOutA;
        tb_d    = RfOutB;
        state_d = ST_WR1;
      end
      ST_WR1: begin
        if (cmd_q.op == OP_SWP) begin
          state_d = ST_WR2;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  // Write-side outputs are decoded straight from state so reset clears them at once.
  always_comb begin
    RegSel  = 4'b0000;
    ScrSel  = 4'b0000;
    FunSel  = FUN_LOAD;
    RfI     = '0;
    OutASel = 3'b000;
    OutBSel = 3'b000;
    case (state_q)
      ST_READ: begin
        OutASel = cmd_q.src;
        OutBSel = cmd_q.dst;
      end
      ST_WR1: begin
        case (cmd_q.op)
          OP_LDI: begin
            {RegSel, ScrSel} = {dst_reg_sel, dst_scr_sel};
            RfI              = imm_q;
          end
          OP_MOV, OP_SWP: begin
            {RegSel, ScrSel} = {dst_reg_sel, dst_scr_sel};
            RfI              = ta_q;
          end
          OP_INC: begin
            {RegSel, ScrSel} = {dst_reg_sel, dst_scr_sel};
            FunSel           = FUN_INC;
          end
          OP_DEC: begin
            {RegSel, ScrSel} = {dst_reg_sel, dst_scr_sel};
            FunSel           = FUN_DEC;
          end
          OP_CLR: begin
            {RegSel, ScrSel} = {dst_reg_sel, dst_scr_sel};
            FunSel           = FUN_CLR;
          end
          OP_CLRALL: begin
            RegSel = 4'b1111;
            ScrSel = 4'b1111;
            FunSel = FUN_CLR;
          end
          default: begin
            RegSel = 4'b0000;
          end
        endcase
      end
      ST_WR2: begin
        {RegSel, ScrSel} = {src_reg_sel, src_scr_sel};
        RfI              = tb_q;
      end
      default: begin
        RegSel = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      imm_q   <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      imm_q   <= imm_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      done_q  <= done_d;
    end
  end

  assign CmdReady = (state_q == ST_IDLE);
  assign Done     = done_q;

endmodule
